// File: rtl/blockram_cfg.sv
// blockram_cfg: configurable-aspect block RAM tile for the fabric BRAM column.
// Four lane-wide storage arrays give per-lane write masking. Reads are
// registered: a capture stage, then an optional output register.
// Narrow reads are right-aligned and zero-extended.
// Optional synchronous FIFO mode is compiled in when BLOCKRAM_CFG_FIFO_MODE_EN
// is defined. Without it, cfg_fifo_mode is ignored and the status outputs are
// tied to their idle values.
module blockram_cfg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_wr_width,
    input  logic [1:0]        cfg_rd_width,
    input  logic              cfg_out_reg,
    input  logic              cfg_fifo_mode,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_lane,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_lane,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);
    localparam int LANE_W = DATA_W / 4;
    localparam int HALF_W = DATA_W / 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Effective mode and acceptance
    logic              fifo_active;
    logic              mode_flush;
    logic              wr_accept;
    logic              rd_accept;
    logic [ADDR_W-1:0] wr_word_addr;
    logic [ADDR_W-1:0] rd_word_addr;
    logic [1:0]        wr_width_eff;
    logic [1:0]        rd_width_eff;
    logic [3:0]        wr_mask;

    // Read pipeline
    logic [DATA_W-1:0] rd_word_s1;
    logic              valid_s1_reg;
    logic [1:0]        width_s1_reg;
    logic [1:0]        lane_s1_reg;
    logic [DATA_W-1:0] lane_mux;
    logic              valid_s2_reg;
    logic [DATA_W-1:0] data_s2_reg;

`ifdef BLOCKRAM_CFG_FIFO_MODE_EN
    logic [ADDR_W-1:0] wp_reg;
    logic [ADDR_W-1:0] rp_reg;
    logic [ADDR_W:0]   level_reg;
    logic [ADDR_W:0]   level_next;
    logic              full_reg;
    logic              empty_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              mode_prev_reg;

    assign fifo_active = cfg_fifo_mode;
    // A change of mode is seen one edge late; that edge flushes the FIFO state.
    assign mode_flush  = (cfg_fifo_mode != mode_prev_reg);

    // Push/pop acceptance uses the pre-edge full/empty flags
    always_comb begin
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        if (!mode_flush) begin
            if (fifo_active) begin
                wr_accept = wr_en && !full_reg;
                rd_accept = rd_en && !empty_reg;
            end else begin
                wr_accept = wr_en;
                rd_accept = rd_en;
            end
        end
    end

    // Occupancy after this edge: +1 push only, -1 pop only, else unchanged
    always_comb begin
        level_next = level_reg;
        if (wr_accept && !rd_accept) begin
            level_next = level_reg + (ADDR_W+1)'(1);
        end else if (rd_accept && !wr_accept) begin
            level_next = level_reg - (ADDR_W+1)'(1);
        end
    end

    // FIFO pointers, occupancy, registered status and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_reg        <= '0;
            rp_reg        <= '0;
            level_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            mode_prev_reg <= cfg_fifo_mode;
        end else begin
            mode_prev_reg <= cfg_fifo_mode;
            if (mode_flush) begin
                wp_reg    <= '0;
                rp_reg    <= '0;
                level_reg <= '0;
                full_reg  <= 1'b0;
                empty_reg <= 1'b1;
            end else if (fifo_active) begin
                if (wr_accept) begin
                    wp_reg <= wp_reg + ADDR_W'(1);
                end
                if (rd_accept) begin
                    rp_reg <= rp_reg + ADDR_W'(1);
                end
                level_reg <= level_next;
                full_reg  <= (level_next == (ADDR_W+1)'(DEPTH));
                empty_reg <= (level_next == '0);
                if (wr_en && full_reg) begin
                    overflow_reg <= 1'b1;
                end
                if (rd_en && empty_reg) begin
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

    assign wr_word_addr = fifo_active ? wp_reg : wr_addr;
    assign rd_word_addr = fifo_active ? rp_reg : rd_addr;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
`else
    logic unused_fifo_mode;

    assign unused_fifo_mode = cfg_fifo_mode;
    assign fifo_active      = 1'b0;
    assign mode_flush       = 1'b0;
    assign wr_accept        = wr_en;
    assign rd_accept        = rd_en;
    assign wr_word_addr     = wr_addr;
    assign rd_word_addr     = rd_addr;
    assign full             = 1'b0;
    assign empty            = 1'b1;
    assign level            = '0;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    // FIFO traffic is always full width; reserved width code 3 acts as full
    assign wr_width_eff = fifo_active ? 2'd0 : cfg_wr_width;
    assign rd_width_eff = fifo_active ? 2'd0 : cfg_rd_width;

    // Lane write mask from write aspect and lane select
    always_comb begin
        wr_mask = 4'b1111;
        case (wr_width_eff)
            2'd1:    wr_mask = wr_lane[0] ? 4'b1100 : 4'b0011;
            2'd2:    wr_mask = 4'b0001 << wr_lane;
            default: wr_mask = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [LANE_W-1:0] mem [DEPTH];
            logic [LANE_W-1:0] lane_wdata;
            logic [LANE_W-1:0] lane_rdata_reg;

            // Narrow writes take their data from the LSBs, replicated across lanes
            always_comb begin
                case (wr_width_eff)
                    2'd1:    lane_wdata = wr_data[(gi % 2)*LANE_W +: LANE_W];
                    2'd2:    lane_wdata = wr_data[LANE_W-1:0];
                    default: lane_wdata = wr_data[gi*LANE_W +: LANE_W];
                endcase
            end

            // Storage write; read-first since the read below sees the old word
            always_ff @(posedge clk) begin
                if (wr_accept && wr_mask[gi]) begin
                    mem[wr_word_addr] <= lane_wdata;
                end
            end

            // Registered read port with output-latch reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_rdata_reg <= '0;
                end else if (rd_accept) begin
                    lane_rdata_reg <= mem[rd_word_addr];
                end
            end

            assign rd_word_s1[gi*LANE_W +: LANE_W] = lane_rdata_reg;
        end
    endgenerate

    // Right-aligned lane select using the aspect captured with the read
    always_comb begin
        lane_mux = rd_word_s1;
        case (width_s1_reg)
            2'd1: lane_mux = {{(DATA_W-HALF_W){1'b0}},
                              (lane_s1_reg[0] ? rd_word_s1[DATA_W-1 -: HALF_W]
                                              : rd_word_s1[HALF_W-1:0])};
            2'd2: lane_mux = {{(DATA_W-LANE_W){1'b0}},
                              rd_word_s1[int'(lane_s1_reg)*LANE_W +: LANE_W]};
            default: lane_mux = rd_word_s1;
        endcase
    end

    // Read control capture and optional output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_reg <= 1'b0;
            width_s1_reg <= 2'd0;
            lane_s1_reg  <= 2'd0;
            valid_s2_reg <= 1'b0;
            data_s2_reg  <= '0;
        end else begin
            valid_s1_reg <= rd_accept;
            if (rd_accept) begin
                width_s1_reg <= rd_width_eff;
                lane_s1_reg  <= fifo_active ? 2'd0 : rd_lane;
            end
            valid_s2_reg <= valid_s1_reg && !mode_flush;
            if (valid_s1_reg && !mode_flush) begin
                data_s2_reg <= lane_mux;
            end
        end
    end

    assign rd_data  = cfg_out_reg ? data_s2_reg : lane_mux;
    assign rd_valid = cfg_out_reg ? valid_s2_reg : valid_s1_reg;

endmodule

// File: tb/tb_blockram_cfg.sv
// tb_blockram_cfg: directed bench for blockram_cfg. Reads push their expected
// data and due cycle into a scoreboard; a negedge monitor pops on rd_valid.
// Define BLOCKRAM_CFG_FIFO_MODE_EN to exercise the FIFO build (ADDR_W=2).
module tb_blockram_cfg;
`ifdef BLOCKRAM_CFG_FIFO_MODE_EN
    localparam int AW = 2;
`else
    localparam int AW = 8;
`endif
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] A5 = AW'(5 & (DEPTH-1));

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg_wr_width, cfg_rd_width;
    logic          cfg_out_reg, cfg_fifo_mode;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    wr_lane, rd_lane;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, overflow, underflow;
    logic [AW:0]   level;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    blockram_cfg #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_width(cfg_wr_width), .cfg_rd_width(cfg_rd_width),
        .cfg_out_reg(cfg_out_reg), .cfg_fifo_mode(cfg_fifo_mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_lane(rd_lane),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rd_valid", 64'(rd_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("read  %-12s data=%08h cyc=%0d", e.name, rd_data, cyc);
                check({e.name, "_data"}, 64'(rd_data), 64'(e.data));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_missing"}, 64'(rd_valid), 64'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        step();
        rst = 1'b0;
        $display("reset cyc=%0d", cyc);
    endtask

    task automatic ram_write(input logic [AW-1:0] a, input logic [1:0] w,
                             input logic [1:0] ln, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; cfg_wr_width = w; wr_lane = ln; wr_data = d;
        $display("write addr=%0d width=%0d lane=%0d data=%08h", a, w, ln, d);
        step();
        wr_en = 1'b0;
    endtask

    // Issue a read; wr_also adds a same-cycle write for read-first checks
    task automatic ram_read(input string name, input logic [AW-1:0] a, input logic [1:0] w,
                            input logic [1:0] ln, input logic [DW-1:0] exp,
                            input logic wr_also, input logic [DW-1:0] wd);
        exp_t e;
        rd_en = 1'b1; rd_addr = a; cfg_rd_width = w; rd_lane = ln;
        wr_en = wr_also; wr_addr = a; cfg_wr_width = 2'd0; wr_data = wd;
        e.data = exp; e.due = cyc + 1 + int'(cfg_out_reg); e.name = name;
        sb.push_back(e);
        step();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic check_status(input string name, input logic f, input logic em,
                                input int lv, input logic ov, input logic un);
        check({name, "_full"}, 64'(full), 64'(f));
        check({name, "_empty"}, 64'(empty), 64'(em));
        check({name, "_level"}, 64'(level), 64'(lv));
        check({name, "_overflow"}, 64'(overflow), 64'(ov));
        check({name, "_underflow"}, 64'(underflow), 64'(un));
    endtask

`ifdef BLOCKRAM_CFG_FIFO_MODE_EN
    task automatic fifo_op(input logic push, input logic [DW-1:0] d,
                           input logic pop, input logic pop_ok, input logic [DW-1:0] exp);
        exp_t e;
        wr_en = push; wr_data = d; rd_en = pop;
        if (pop && pop_ok) begin
            e.data = exp; e.due = cyc + 1 + int'(cfg_out_reg); e.name = "fifo_pop";
            sb.push_back(e);
        end
        $display("fifo push=%0d data=%08h pop=%0d", push, d, pop);
        step();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask
`endif

    initial begin
        cfg_wr_width = 2'd0; cfg_rd_width = 2'd0; cfg_out_reg = 1'b0; cfg_fifo_mode = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0;
        wr_lane = 2'd0; rd_lane = 2'd0; wr_data = '0; rst = 1'b1;
        step();
        do_reset();
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check_status("reset", 1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Width mix, no output register then with it
        ram_write(A5, 2'd0, 2'd0, 32'hDEADBEEF);
        ram_write(A5, 2'd2, 2'd2, 32'h00000011);
        ram_read("full_or0", A5, 2'd0, 2'd0, 32'hDE11BEEF, 1'b0, '0);
        wait_cycles(3);
        cfg_out_reg = 1'b1;
        ram_read("full_or1", A5, 2'd0, 2'd0, 32'hDE11BEEF, 1'b0, '0);
        wait_cycles(3);
        cfg_out_reg = 1'b0;

        // Narrow reads back-to-back
        ram_read("half_l1", A5, 2'd1, 2'd1, 32'h0000DE11, 1'b0, '0);
        ram_read("quart_l3", A5, 2'd2, 2'd3, 32'h000000DE, 1'b0, '0);
        ram_read("quart_l0", A5, 2'd2, 2'd0, 32'h000000EF, 1'b0, '0);
        ram_read("resv_w3", A5, 2'd3, 2'd1, 32'hDE11BEEF, 1'b0, '0);

        // Read-first on same-cycle write, then new data visible
        ram_read("rd_first", A5, 2'd0, 2'd0, 32'hDE11BEEF, 1'b1, 32'h0);
        ram_read("after_wr", A5, 2'd0, 2'd0, 32'h00000000, 1'b0, '0);

        // Half write preserves the other half; rd_data holds when idle
        ram_write(A5, 2'd0, 2'd0, 32'hCAFEF00D);
        ram_write(A5, 2'd1, 2'd0, 32'h0000AAAA);
        ram_read("half_wr", A5, 2'd0, 2'd0, 32'hCAFEAAAA, 1'b0, '0);
        wait_cycles(4);
        check("hold_rd_data", 64'(rd_data), 64'hCAFEAAAA);

        // Reset one cycle after a registered-output read: no rd_valid allowed
        cfg_out_reg = 1'b1;
        rd_en = 1'b1; rd_addr = A5; cfg_rd_width = 2'd0;
        step();
        rd_en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        wait_cycles(4);
        check("rst_mid_rd_data", 64'(rd_data), 64'd0);
        check("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
        cfg_out_reg = 1'b0;

`ifdef BLOCKRAM_CFG_FIFO_MODE_EN
        // Fill / drain with overflow and underflow
        cfg_fifo_mode = 1'b1;
        wait_cycles(2);
        check_status("fifo_start", 1'b0, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) fifo_op(1'b1, DW'(i), 1'b0, 1'b0, '0);
        check_status("fifo_full", 1'b1, 1'b0, DEPTH, 1'b0, 1'b0);
        fifo_op(1'b1, 32'd5, 1'b0, 1'b0, '0);
        check_status("fifo_ovf", 1'b1, 1'b0, DEPTH, 1'b1, 1'b0);
        for (int i = 1; i <= DEPTH; i++) fifo_op(1'b0, '0, 1'b1, 1'b1, DW'(i));
        check_status("fifo_drained", 1'b0, 1'b1, 0, 1'b1, 1'b0);
        fifo_op(1'b0, '0, 1'b1, 1'b0, '0);
        wait_cycles(2);
        check_status("fifo_unf", 1'b0, 1'b1, 0, 1'b1, 1'b1);

        // Reset clears flags; push+pop when empty, then interleaved wrap
        do_reset();
        check_status("fifo_rst", 1'b0, 1'b1, 0, 1'b0, 1'b0);
        fifo_op(1'b1, 32'd100, 1'b1, 1'b0, '0);
        check_status("fifo_pp_empty", 1'b0, 1'b0, 1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) fifo_op(1'b1, DW'(101 + i), 1'b1, 1'b1, DW'(100 + i));
        check_status("fifo_wrap", 1'b0, 1'b0, 1, 1'b0, 1'b1);
        fifo_op(1'b0, '0, 1'b1, 1'b1, 32'd110);
        wait_cycles(2);
        check_status("fifo_final", 1'b0, 1'b1, 0, 1'b0, 1'b1);
`else
        // FIFO request ignored: RAM addressing and constant status
        cfg_fifo_mode = 1'b1;
        ram_write(AW'(9), 2'd0, 2'd0, 32'h12345678);
        ram_write(AW'(10), 2'd0, 2'd0, 32'h9ABCDEF0);
        ram_write(AW'(9), 2'd2, 2'd1, 32'h00000077);
        ram_read("nofifo_a9", AW'(9), 2'd0, 2'd0, 32'h12347778, 1'b0, '0);
        ram_read("nofifo_a10", AW'(10), 2'd1, 2'd1, 32'h00009ABC, 1'b0, '0);
        ram_read("nofifo_a9b", AW'(9), 2'd0, 2'd0, 32'h12347778, 1'b0, '0);
        wait_cycles(2);
        check_status("nofifo", 1'b0, 1'b1, 0, 1'b0, 1'b0);
`endif

        wait_cycles(4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/blockram_cfg.md
# blockram_cfg

Parametrised, configurable-aspect block RAM tile for the eFPGA fabric with registered synchronous reads, per-lane write masking, an optional output register and an optional built-in synchronous FIFO mode. It sits in the fabric's BRAM column. Configuration bits come from the fabric configuration chain. Lane selects and enables are explicit ports rather than borrowed data bits. Storage is an inferred array of `2**ADDR_W` words of `DATA_W` bits.

## Interface
- `DATA_W`, 32, word width; must be a multiple of 32/8 lanes, i.e. divisible by 4.
- `ADDR_W`, 8, word address width; depth = 2**ADDR_W.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_wr_width` in 2: write aspect. 0 = full word, 1 = half (DATA_W/2), 2 = quarter (DATA_W/4), 3 = reserved (treated as 0).
- `cfg_rd_width` in 2: read aspect, same encoding as `cfg_wr_width`.
- `cfg_out_reg` in 1: 1 = extra output register stage.
- `cfg_fifo_mode` in 1: 1 = FIFO mode (only with macro).
- `wr_en` in 1: write / push request.
- `wr_addr` in ADDR_W: write word address (ignored in FIFO mode).
- `wr_lane` in 2: sub-word select. Half width uses bit 0; quarter width uses both bits.
- `wr_data` in DATA_W: write data; narrow writes use the LSBs.
- `rd_en` in 1: read / pop request.
- `rd_addr` in ADDR_W: read word address (ignored in FIFO mode).
- `rd_lane` in 2: read sub-word select.
- `rd_data` out DATA_W: read data; narrow reads are right-aligned and upper bits are zero.
- `rd_valid` out 1: `rd_data` holds the result of an accepted read.
- `full`, `empty` out 1: FIFO status.
- `level` out ADDR_W+1: FIFO occupancy.
- `overflow`, `underflow` out 1: sticky FIFO error flags.

## Operation
- **Write, RAM mode:** when `wr_en` is 1, write on the edge using a lane mask.
  - Full width: all lanes written.
  - Half width: `wr_lane[0]` selects the low or high half.
  - Quarter width: `wr_lane` selects the quarter.
  - Unselected lanes are preserved.
- **Read, RAM mode:** when `rd_en` is 1, `rd_addr`, `rd_lane` and `cfg_rd_width` are captured together. The lane mux uses the captured values.
- **Read-during-write to the same word:** read-first; the old data is returned.
- **FIFO mode (macro enabled, `cfg_fifo_mode`=1):**
  - Full width only; `cfg_*_width` and the lane ports are ignored.
  - Write pointer `wp`, read pointer `rp` and `level` are ADDR_W, ADDR_W and ADDR_W+1 bits wide.
  - Push is accepted when `wr_en` is 1 and `full` is 0: write at `wp`, then `wp`+1.
  - Pop is accepted when `rd_en` is 1 and `empty` is 0: read at `rp`, then `rp`+1.
  - Pointers wrap modulo 2**ADDR_W.
  - `level` increments by 1 on push only, decrements by 1 on pop only, and is unchanged on both.
  - `full` = (`level` == 2**ADDR_W); `empty` = (`level` == 0).
  - Push while full is dropped and sets `overflow`, even if a pop happens in the same cycle.
  - Pop while empty is dropped and sets `underflow`, even if a push happens in the same cycle; no `rd_valid` is produced.
  - `overflow` and `underflow` are sticky until `rst`.
- **Mode change:** any change of `cfg_fifo_mode` clears `wp`, `rp` and `level` on the following edge and drops in-flight reads. Memory contents are kept.
- **Reset values:**
  - `rd_data`=0, `rd_valid`=0.
  - `level`=0, `empty`=1, `full`=0.
  - `overflow`=0, `underflow`=0.
  - Pointers = 0.
  - Memory is not reset.

## Timing
- Read latency is measured from the edge that samples an accepted `rd_en`:
  - `cfg_out_reg`=0: `rd_data` and `rd_valid` change 1 cycle later.
  - `cfg_out_reg`=1: they change 2 cycles later.
- `rd_valid` is a pulse aligned with its data. `rd_data` holds its value when no read is accepted.
- Back-to-back reads give one result per cycle.
- Status outputs are registered:
  - `full`, `empty` and `level` reflect pushes and pops on the edge that accepts them.
  - Acceptance uses the pre-edge values.
- `rst` mid-operation clears every pipeline stage on that edge. No `rd_valid` is emitted for reads issued before or in the reset cycle.
- A write is visible to a read issued on the next cycle or later.

## Configuration
- `BLOCKRAM_CFG_FIFO_MODE_EN` **defined:** FIFO pointers, level counter, flags and mode-change clear are present.
- **Not defined:**
  - `cfg_fifo_mode` is ignored and the block is pure RAM.
  - `full`=0, `empty`=1, `level`=0, `overflow`=0 and `underflow`=0, all constant.
  - No pointer logic is synthesised.

## Test plan
- **RAM width mix:** full write 0xDEADBEEF @5; quarter write 0x11 lane 2 @5; full read @5.
  - `cfg_out_reg`=0: 0xDE11BEEF with `rd_valid` at +1 cycle.
  - `cfg_out_reg`=1: same data at +2 cycles.
- **Narrow read and read-first:** half read @5 lane 1 -> 0x0000DE11. Same-cycle write 0x0 and read @5 -> old 0xDE11BEEF; the next read returns 0x0.
- **FIFO fill/drain, ADDR_W=2:** push 1..4 -> `full`=1, `level`=4. A 5th push sets `overflow` and is dropped. Four pops return 1,2,3,4, then `empty`=1. A 5th pop sets `underflow` with no `rd_valid`.
- **FIFO wrap and simultaneous push/pop:** run 10 interleaved push+pop pairs -> `level` constant, data in order across the pointer wrap. Push+pop when empty -> push accepted, `level`=1, `underflow`=1.
- **Reset mid-read:** assert `rst` one cycle after `rd_en` with `cfg_out_reg`=1 -> `rd_valid` never pulses. Outputs go to reset values and flags clear.
- **Macro off:** drive `cfg_fifo_mode`=1 -> RAM addressing is still honoured and status outputs stay constant.
